// File: rtl/key_event_fsm.sv
// ---------------------------------------------------------------------------
// key_event_fsm
//
// Front-end conditioning for the board keys. Every raw key pin is brought
// into the clk domain with a two-flop synchroniser and then debounced by its
// own small state machine that is only evaluated on a shared sample tick.
// The result is a clean pressed level plus single-cycle press, release and
// long-press pulses for the downstream LED / key-action logic.
//
// Ports:
//   clk          system clock (50 MHz on the board)
//   rst_n        asynchronous, active-low reset
//   key_in       raw key pins, 0 = pressed
//   key_level    debounced key state, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
//   key_long     one-cycle pulse when a hold reaches LONG_TICKS ticks
//
// Optional feature (compile-time macro KEY_AUTOREPEAT_EN):
//   When defined, key_press re-fires every REPEAT_TICKS ticks once key_long
//   has fired and the key is still held. When undefined there is no repeat
//   counter at all and key_press fires once per accepted press.
// ---------------------------------------------------------------------------
module key_event_fsm #(
    parameter int NUM_KEYS      = 4,
    parameter int SAMPLE_CYCLES = 50000,
    parameter int STABLE_TICKS  = 20,
    parameter int LONG_TICKS    = 1000,
    parameter int REPEAT_TICKS  = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int TICK_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
`endif

    // Reject nonsensical configurations at elaboration time.
    if (SAMPLE_CYCLES < 1 || STABLE_TICKS < 1 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("key_event_fsm: SAMPLE_CYCLES, STABLE_TICKS, LONG_TICKS and REPEAT_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } key_state_t;

    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;
    logic [NUM_KEYS-1:0] p_sync;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;

    // Two-flop synchroniser; flops come out of reset as "released" (1) so a
    // key held down through reset still has to be debounced afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    assign p_sync = ~sync_q2;

    // Shared sample-tick divider: counts 0..SAMPLE_CYCLES-1 and wraps. The
    // tick is the cycle in which the counter sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_state_t        state_q;
        key_state_t        state_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              level_q;
        logic              level_d;
        logic              press_q;
        logic              press_d;
        logic              release_q;
        logic              release_d;
        logic              long_q;
        logic              long_d;
`ifdef KEY_AUTOREPEAT_EN
        logic [REP_W-1:0]  rep_q;
        logic [REP_W-1:0]  rep_d;
`endif

        // State, counters and registered outputs for this key.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                hold_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                rep_q     <= '0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                hold_q    <= hold_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
`ifdef KEY_AUTOREPEAT_EN
                rep_q     <= rep_d;
`endif
            end
        end

        // Debounce decisions, taken only on tick cycles. Pulses default to 0
        // so they last exactly one clk cycle after the deciding tick; the
        // level and counters simply hold between ticks.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            hold_d    = hold_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_d     = rep_q;
`endif
            if (tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (p_sync[k]) begin
                            if (STABLE_TICKS == 1) begin
                                state_d = HELD;
                                level_d = 1'b1;
                                press_d = 1'b1;
                                hold_d  = '0;
                                cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
                                rep_d   = '0;
`endif
                            end else begin
                                state_d = PRESS_CHK;
                                cnt_d   = CNT_ONE;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (!p_sync[k]) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = HELD;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            hold_d  = '0;
                            cnt_d   = '0;
`ifdef KEY_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        // A single-sample debounce has no release check to
                        // sit in, so the release is accepted immediately.
                        if (!p_sync[k]) begin
                            if (STABLE_TICKS == 1) begin
                                state_d   = IDLE;
                                level_d   = 1'b0;
                                release_d = 1'b1;
                                hold_d    = '0;
                                cnt_d     = '0;
                            end else begin
                                state_d = RELEASE_CHK;
                                cnt_d   = CNT_ONE;
                            end
`ifdef KEY_AUTOREPEAT_EN
                            rep_d = '0;
`endif
                        end else if (hold_q != HOLD_MAX) begin
                            // hold_cnt saturates, so long fires once per press
                            // even across release glitches.
                            hold_d = hold_q + 1'b1;
                            if (hold_q == HOLD_LAST) begin
                                long_d = 1'b1;
                            end
                        end
`ifdef KEY_AUTOREPEAT_EN
                        else begin
                            if (rep_q == REP_LAST) begin
                                press_d = 1'b1;
                                rep_d   = '0;
                            end else begin
                                rep_d = rep_q + 1'b1;
                            end
                        end
`endif
                    end
                    RELEASE_CHK: begin
                        // Going back to HELD keeps hold_cnt so a glitch does
                        // not restart the long-press timer.
                        if (p_sync[k]) begin
                            state_d = HELD;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d   = IDLE;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                            cnt_d     = '0;
                            hold_d    = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_long[k]    = long_q;
    end

endmodule

// File: tb/tb_key_event_fsm.sv
// ---------------------------------------------------------------------------
// tb_key_event_fsm
//
// Directed bench for key_event_fsm with a small configuration
// (SAMPLE_CYCLES=4, STABLE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4).
// A tick-level behavioural model (streak / hold counting per key) predicts
// the outputs and is compared against the DUT on every negedge, and a set
// of hand-computed literal expectations pins event counts and latencies.
// Honours KEY_AUTOREPEAT_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_event_fsm;

    localparam int NK = 4;
    localparam int SC = 4;
    localparam int ST = 3;
    localparam int LT = 10;
    localparam int RT = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    int checks   = 0;
    int failures = 0;

    key_event_fsm #(
        .NUM_KEYS      (NK),
        .SAMPLE_CYCLES (SC),
        .STABLE_TICKS  (ST),
        .LONG_TICKS    (LT),
        .REPEAT_TICKS  (RT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    // 10 ns clock: posedges at 5, 15, ...; inputs change and outputs are
    // sampled on negedges.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive a key pattern and let it sit for a whole number of sample ticks.
    task automatic applyStimulus(input logic [NK-1:0] keys, input int ticks);
        key_in = keys;
        repeat (ticks * SC) @(negedge clk);
    endtask

    // Behavioural model: keys are sampled once per tick through a two-stage
    // delay; a key flips its debounced level after ST consecutive samples
    // disagreeing with it, and counts steady held samples toward LT.
    logic [NK-1:0] m_s1;
    logic [NK-1:0] m_s2;
    logic [NK-1:0] m_lvl;
    int            m_phase;
    int            m_streak [NK];
    int            m_held   [NK];
    int            m_rep    [NK];
    logic [NK-1:0] exp_level;
    logic [NK-1:0] exp_press;
    logic [NK-1:0] exp_release;
    logic [NK-1:0] exp_long;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1        = '1;
            m_s2        = '1;
            m_lvl       = '0;
            m_phase     = 0;
            exp_level   = '0;
            exp_press   = '0;
            exp_release = '0;
            exp_long    = '0;
            for (int k = 0; k < NK; k++) begin
                m_streak[k] = 0;
                m_held[k]   = 0;
                m_rep[k]    = 0;
            end
        end else begin
            exp_press   = '0;
            exp_release = '0;
            exp_long    = '0;
            if (m_phase == SC - 1) begin
                for (int k = 0; k < NK; k++) begin
                    logic sample;
                    sample = ~m_s2[k];
                    if (sample != m_lvl[k]) begin
                        m_streak[k]++;
                        if (m_lvl[k] && m_streak[k] == 1) m_rep[k] = 0;
                        if (m_streak[k] == ST) begin
                            m_lvl[k]    = sample;
                            m_streak[k] = 0;
                            if (sample) begin
                                exp_press[k] = 1'b1;
                                m_held[k]    = 0;
                                m_rep[k]     = 0;
                            end else begin
                                exp_release[k] = 1'b1;
                            end
                        end
                    end else begin
                        if (m_lvl[k] && m_streak[k] == 0) begin
                            if (m_held[k] < LT) begin
                                m_held[k]++;
                                if (m_held[k] == LT) exp_long[k] = 1'b1;
                            end else begin
`ifdef KEY_AUTOREPEAT_EN
                                m_rep[k]++;
                                if (m_rep[k] == RT) begin
                                    exp_press[k] = 1'b1;
                                    m_rep[k]     = 0;
                                end
`endif
                            end
                        end
                        m_streak[k] = 0;
                    end
                end
                exp_level = m_lvl;
            end
            m_phase = (m_phase + 1) % SC;
            m_s2    = m_s1;
            m_s1    = key_in;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checkOutput("model_level",   int'(key_level),   int'(exp_level));
        checkOutput("model_press",   int'(key_press),   int'(exp_press));
        checkOutput("model_release", int'(key_release), int'(exp_release));
        checkOutput("model_long",    int'(key_long),    int'(exp_long));
    end

    // Event bookkeeping used by the literal expectations.
    int            edge_cnt = 0;
    int            press_cnt   [NK] = '{default: 0};
    int            release_cnt [NK] = '{default: 0};
    int            long_cnt    [NK] = '{default: 0};
    int            last_press_edge   [NK] = '{default: -1};
    int            last_release_edge [NK] = '{default: -1};
    int            last_long_edge    [NK] = '{default: -1};
    logic [NK-1:0] last_press_vec = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (key_press[k] === 1'b1) begin
                press_cnt[k]++;
                last_press_edge[k] = edge_cnt;
            end
            if (key_release[k] === 1'b1) begin
                release_cnt[k]++;
                last_release_edge[k] = edge_cnt;
            end
            if (key_long[k] === 1'b1) begin
                long_cnt[k]++;
                last_long_edge[k] = edge_cnt;
            end
        end
        if (key_press !== '0) last_press_vec = key_press;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int h;
        int exp_key0_press;

`ifdef KEY_AUTOREPEAT_EN
        exp_key0_press = 2;
`else
        exp_key0_press = 1;
`endif

        // Reset with every key down: outputs must stay quiet.
        rst_n  = 1'b0;
        key_in = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_level",   int'(key_level),   0);
        checkOutput("reset_press",   int'(key_press),   0);
        checkOutput("reset_release", int'(key_release), 0);
        checkOutput("reset_long",    int'(key_long),    0);
        rst_n  = 1'b1;
        key_in = 4'b1111;
        applyStimulus(4'b1111, 2);

        // Clean press on key 0: press pulse 12 edges after the pin change.
        t0 = edge_cnt;
        applyStimulus(4'b1110, 6);
        checkOutput("clean_press_count",   press_cnt[0], 1);
        checkOutput("clean_press_latency", last_press_edge[0] - t0, 12);
        checkOutput("clean_level",         int'(key_level), 1);
        checkOutput("clean_other_presses", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // Keep holding to 15 ticks in HELD: one long pulse at HELD tick 10.
        applyStimulus(4'b1110, 12);
        checkOutput("long_count",   long_cnt[0], 1);
        checkOutput("long_latency", last_long_edge[0] - t0, 52);
        checkOutput("long_presses", press_cnt[0], exp_key0_press);

        // One-tick release glitch must not release the key.
        applyStimulus(4'b1111, 1);
        applyStimulus(4'b1110, 1);
        checkOutput("glitch_release_count", release_cnt[0], 0);
        checkOutput("glitch_level",         int'(key_level), 1);

        // A real release: pulse 12 edges after the pin goes high.
        h = edge_cnt;
        applyStimulus(4'b1111, 4);
        checkOutput("release_count",   release_cnt[0], 1);
        checkOutput("release_latency", last_release_edge[0] - h, 12);
        checkOutput("release_level",   int'(key_level), 0);
        checkOutput("release_long",    long_cnt[0], 1);

        // Bounce on key 1: toggling every tick never debounces.
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b1101 : 4'b1111, 1);
        end
        applyStimulus(4'b1111, 4);
        checkOutput("bounce_press",   press_cnt[1], 0);
        checkOutput("bounce_release", release_cnt[1], 0);
        checkOutput("bounce_level",   int'(key_level), 0);

        // Keys 0 and 3 pressed together pulse in the same cycle.
        t0 = edge_cnt;
        applyStimulus(4'b0110, 4);
        checkOutput("simul_press_vec",     int'(last_press_vec), 9);
        checkOutput("simul_press_latency", last_press_edge[3] - t0, 12);
        checkOutput("simul_same_edge",     last_press_edge[0] - last_press_edge[3], 0);
        checkOutput("simul_level",         int'(key_level), 9);

        // Mid-operation reset: level drops at once, no release pulse.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_level",   int'(key_level), 0);
        checkOutput("midreset_release", int'(key_release), 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        key_in = 4'b1111;
        applyStimulus(4'b1111, 2);
        checkOutput("midreset_release_total", release_cnt[0] + release_cnt[3], 1);
        checkOutput("midreset_level_after",   int'(key_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event_fsm.md
Name: key_event_fsm

Overview:
- Front-end conditioning stage for the board keys (KEY1..KEY4, active-low, 50 MHz clk).
- Synchronises raw key inputs and debounces each key with its own state machine.
- Emits a clean level plus single-cycle press, release and long-press event pulses.
- Directly feeds the LED and key-action logic, which consume the pulses instead of sampling raw pins.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- SAMPLE_CYCLES, 50000, clk cycles per sample tick (1 ms at 50 MHz).
- STABLE_TICKS, 20, consecutive identical samples needed to accept a press or release (>=1).
- LONG_TICKS, 1000, ticks in HELD before key_long fires (>=1).
- REPEAT_TICKS, 200, auto-repeat period in ticks; used only with the optional feature.

Ports:
- clk, input, 1, system clock, 50 MHz.
- rst_n, input, 1, asynchronous active-low reset.
- key_in, input, NUM_KEYS, raw key pins; 0 = pressed.
- key_level, output, NUM_KEYS, debounced state; 1 = pressed.
- key_press, output, NUM_KEYS, one-cycle pulse on accepted press.
- key_release, output, NUM_KEYS, one-cycle pulse on accepted release.
- key_long, output, NUM_KEYS, one-cycle pulse when hold reaches LONG_TICKS.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, all FSMs IDLE, all counters 0, synchroniser flops 1 (released).
- Synchroniser: 2-FF per key on key_in, inverted to give pressed = 1 (p_sync).
- Tick generator:
  - Shared counter from 0 to SAMPLE_CYCLES-1, then wraps.
  - tick is high for one cycle when the counter equals SAMPLE_CYCLES-1.
  - First tick occurs SAMPLE_CYCLES cycles after reset release.
- Per-key FSM: evaluated only on tick cycles; state, counters and outputs hold otherwise.
  - IDLE: if p_sync=1, go to PRESS_CHK with cnt=1. If STABLE_TICKS=1, go directly to HELD and fire press.
  - PRESS_CHK:
    - p_sync=0: back to IDLE, cnt=0.
    - p_sync=1 and cnt+1==STABLE_TICKS: go to HELD, key_level=1, key_press pulse, hold_cnt=0.
    - Otherwise: cnt++.
  - HELD:
    - p_sync=0: go to RELEASE_CHK with cnt=1.
    - Otherwise: hold_cnt++, saturating at LONG_TICKS.
    - On the tick where hold_cnt becomes LONG_TICKS, fire key_long. It fires once per press.
  - RELEASE_CHK:
    - p_sync=1: back to HELD; hold_cnt is preserved, not reset.
    - p_sync=0 and cnt+1==STABLE_TICKS: go to IDLE, key_level=0, key_release pulse.
    - Otherwise: cnt++.
- Pulse timing:
  - All outputs are registered.
  - Each pulse is high for exactly the clk cycle after the deciding tick.
- Independence and simultaneous events:
  - Keys are fully independent; several keys may pulse in the same cycle.
  - press/release and long cannot coincide on one key.
- Counter widths:
  - cnt is clog2(STABLE_TICKS+1) bits.
  - hold_cnt is clog2(LONG_TICKS+1) bits.
  - No wrap-around; hold_cnt saturates.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronous); no key_release is generated.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - After key_long fires, key_press re-pulses every REPEAT_TICKS ticks while the key stays in HELD.
  - The repeat counter restarts on entry to RELEASE_CHK and stops when the key leaves HELD.
- Undefined: no repeat logic and no repeat counter. key_press fires exactly once per accepted press.

Test Plan (SAMPLE_CYCLES=4, STABLE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4):
- Reset: assert rst_n=0 with key_in=4'b0000 -> all outputs 0 throughout reset; FSMs IDLE after release.
- Clean press: key_in[0]=0 held for 6 ticks -> key_press[0] is a 1-cycle pulse after the 3rd consecutive pressed tick; key_level[0]=1; others 0.
- Bounce: key_in[1] toggles every tick for 8 ticks, then goes high -> no key_press or key_release; key_level[1] stays 0.
- Long hold: key0 held for 15 ticks in HELD -> exactly one key_long[0] at HELD tick 10. With KEY_AUTOREPEAT_EN, key_press[0] also fires at HELD ticks 14, 18, ...
- Release glitch: during HELD, key_in[0] goes high for 1 tick, then low -> no release and key_level stays 1. A high for 3 ticks then gives key_release[0] and key_level[0]=0.
- Simultaneous keys and mid-op reset: key0 and key3 pressed on the same cycle -> key_press=4'b1001 in one cycle. Then rst_n=0 while HELD -> key_level=0 at once, with no key_release pulse.
